cordic_sincos_ctrl: RTL and testbench

- Sequencer for the shared iterative CORDIC sin/cos engine.
- Accepts a range-reduced angle residue plus its sign and quadrant tags, then loads the core and steps it through ITER micro-rotations.
- Captures the raw fixed-point sin/cos results and presents them, with the matching sign/quadrant tags, to the float post-processing stage through a valid/ready handshake.

---
 rtl/cordic_sincos_ctrl_if.sv | 36 +++
 rtl/cordic_sincos_ctrl.sv | 119 +++++++++++
 tb/tb_cordic_sincos_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sincos_ctrl_if.sv
// Request, core-drive and result signals of the CORDIC sin/cos sequencer.
// slave = the sequencer itself, master = its surroundings (requester, core, post-processing).
interface cordic_sincos_ctrl_if #(
  parameter int IW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [29:0]   in_angle;
  logic          in_sign;
  logic [1:0]    in_quadrant;
  logic [29:0]   core_angle;
  logic          core_load;
  logic          core_en;
  logic [IW-1:0] core_iter;
  logic [29:0]   core_sin;
  logic [29:0]   core_cos;
  logic          out_valid;
  logic          out_ready;
  logic [29:0]   pre_sin;
  logic [29:0]   pre_cos;
  logic          sign;
  logic [1:0]    quadrant;
  logic          busy;

  modport slave (
    input  in_valid, in_angle, in_sign, in_quadrant, core_sin, core_cos, out_ready,
    output in_ready, core_angle, core_load, core_en, core_iter,
           out_valid, pre_sin, pre_cos, sign, quadrant, busy
  );

  modport master (
    output in_valid, in_angle, in_sign, in_quadrant, core_sin, core_cos, out_ready,
    input  in_ready, core_angle, core_load, core_en, core_iter,
           out_valid, pre_sin, pre_cos, sign, quadrant, busy
  );
endinterface

// File: rtl/cordic_sincos_ctrl.sv
// Sequencer for the shared iterative CORDIC sin/cos core: load, ITER rotations, hand off result.
// Optional macro CORDIC_ZERO_BYPASS_EN: zero angles skip the core and complete in one cycle.
module cordic_sincos_ctrl #(
  parameter int ITER = 24,
  parameter int IW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  cordic_sincos_ctrl_if.slave bus
);

  localparam logic [IW-1:0] LAST  = IW'(ITER - 1);
  localparam logic [29:0]   ONE_Q = 30'h1000_0000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_DONE} state_t;

  state_t        state, state_d, req_state;
  logic [IW-1:0] cnt, cnt_d;
  logic          rdy_en;
  logic          in_ready_c;
  logic          accept;
  logic          zero_req;
  logic          cap_core;
  logic          take_zero;

  logic [29:0]   angle_r;
  logic [29:0]   pre_sin_r;
  logic [29:0]   pre_cos_r;
  logic          sign_r;
  logic [1:0]    quad_r;

  // rdy_en keeps in_ready low during reset and until the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cap_core   = 1'b0;
    in_ready_c = rdy_en && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
    accept     = bus.in_valid && in_ready_c;
`ifdef CORDIC_ZERO_BYPASS_EN
    zero_req   = (bus.in_angle == '0);
`else
    zero_req   = 1'b0;
`endif
    req_state  = zero_req ? S_DONE : S_LOAD;
    take_zero  = accept && zero_req;

    case (state)
      S_IDLE: begin
        if (accept) state_d = req_state;
      end
      S_LOAD: begin
        state_d = S_ROT;
        cnt_d   = '0;
      end
      S_ROT: begin
        // Terminate on an explicit compare so the index never wraps
        if (cnt == LAST) begin
          state_d  = S_DONE;
          cap_core = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = accept ? req_state : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result and tag registers are cleared by reset so every output reads zero while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_r   <= '0;
      sign_r    <= 1'b0;
      quad_r    <= '0;
      pre_sin_r <= '0;
      pre_cos_r <= '0;
    end else begin
      if (accept) begin
        angle_r <= bus.in_angle;
        sign_r  <= bus.in_sign;
        quad_r  <= bus.in_quadrant;
      end
      if (cap_core) begin
        pre_sin_r <= bus.core_sin;
        pre_cos_r <= bus.core_cos;
      end else if (take_zero) begin
        pre_sin_r <= '0;
        pre_cos_r <= ONE_Q;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.core_angle = angle_r;
  assign bus.core_load  = (state == S_LOAD);
  assign bus.core_en    = (state == S_ROT);
  assign bus.core_iter  = (state == S_ROT) ? cnt : '0;
  assign bus.out_valid  = (state == S_DONE);
  assign bus.pre_sin    = pre_sin_r;
  assign bus.pre_cos    = pre_cos_r;
  assign bus.sign       = sign_r;
  assign bus.quadrant   = quad_r;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// Directed bench for cordic_sincos_ctrl with a behavioural stand-in for the CORDIC core.
// Honours CORDIC_ZERO_BYPASS_EN for the zero-angle case.
module tb_cordic_sincos_ctrl;

  localparam int ITER = 24;
  localparam int IW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_sincos_ctrl_if #(.IW(IW)) bus ();

  cordic_sincos_ctrl #(.ITER(ITER), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Stand-in core: one arbitrary but order-sensitive update per enabled cycle;
  // outputs show the accumulator after the current cycle's rotation.
  function automatic logic [29:0] rot_s(input logic [29:0] s, input logic [29:0] a, input int i);
    return s + (a >> i) + 30'(i);
  endfunction

  function automatic logic [29:0] rot_c(input logic [29:0] c, input logic [29:0] a, input int i);
    return c - (a >> i) + 30'(3 * i);
  endfunction

  function automatic logic [29:0] model_sin(input logic [29:0] a);
    logic [29:0] s = 30'h0;
    for (int i = 0; i < ITER; i++) s = rot_s(s, a, i);
    return s;
  endfunction

  function automatic logic [29:0] model_cos(input logic [29:0] a);
    logic [29:0] c = 30'h1000_0000;
    for (int i = 0; i < ITER; i++) c = rot_c(c, a, i);
    return c;
  endfunction

  logic [29:0] m_ang, m_s, m_c;
  always @(posedge clk) begin
    if (bus.core_load) begin
      m_ang <= bus.core_angle;
      m_s   <= 30'h0;
      m_c   <= 30'h1000_0000;
    end else if (bus.core_en) begin
      m_s <= rot_s(m_s, m_ang, int'(bus.core_iter));
      m_c <= rot_c(m_c, m_ang, int'(bus.core_iter));
    end
  end
  assign bus.core_sin = bus.core_en ? rot_s(m_s, m_ang, int'(bus.core_iter)) : m_s;
  assign bus.core_cos = bus.core_en ? rot_c(m_c, m_ang, int'(bus.core_iter)) : m_c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] angle;
    logic        sign;
    logic [1:0]  quad;
    int          hold;
    logic [29:0] exp_sin;
    logic [29:0] exp_cos;
    logic        exp_sign;
    logic [1:0]  exp_quad;
  } vec_t;

  vec_t vecs[3];

  // Starts mid-cycle with the DUT idle; ends at a negedge in DONE with out_ready low.
  task automatic do_txn(input vec_t v);
    logic [29:0] s0, c0;
    bus.in_valid    = 1'b1;
    bus.in_angle    = v.angle;
    bus.in_sign     = v.sign;
    bus.in_quadrant = v.quad;
    bus.out_ready   = 1'b0;
    #1;
    chk("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_angle = ~v.angle;
    for (int c = 1; c <= ITER + 1; c++) begin
      @(negedge clk);
      chk($sformatf("core_load c%0d", c), bus.core_load, (c == 1) ? 1 : 0);
      chk($sformatf("core_en c%0d", c), bus.core_en, (c >= 2) ? 1 : 0);
      chk($sformatf("core_iter c%0d", c), bus.core_iter, (c >= 2) ? c - 2 : 0);
      chk($sformatf("out_valid c%0d", c), bus.out_valid, 0);
      chk($sformatf("busy c%0d", c), bus.busy, 1);
      chk($sformatf("in_ready c%0d", c), bus.in_ready, 0);
      if (c == 1) chk("core_angle", bus.core_angle, v.angle);
    end
    @(negedge clk);
    chk("done out_valid", bus.out_valid, 1);
    chk("done core_en", bus.core_en, 0);
    chk("done pre_sin", bus.pre_sin, v.exp_sin);
    chk("done pre_cos", bus.pre_cos, v.exp_cos);
    chk("done sign", bus.sign, v.exp_sign);
    chk("done quadrant", bus.quadrant, v.exp_quad);
    s0 = bus.pre_sin;
    c0 = bus.pre_cos;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", h), bus.out_valid, 1);
      chk($sformatf("hold%0d in_ready", h), bus.in_ready, 0);
      chk($sformatf("hold%0d pre_sin", h), bus.pre_sin, s0);
      chk($sformatf("hold%0d pre_cos", h), bus.pre_cos, c0);
      chk($sformatf("hold%0d sign", h), bus.sign, v.exp_sign);
      chk($sformatf("hold%0d quadrant", h), bus.quadrant, v.exp_quad);
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", bus.in_ready, 1);
    chk("release out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("after out_valid", bus.out_valid, 0);
    chk("after busy", bus.busy, 0);
    chk("after in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [29:0] a2;

    vecs[0] = '{angle: 30'h0C90_FDAA, sign: 1'b1, quad: 2'd2, hold: 10,
                exp_sin: model_sin(30'h0C90_FDAA), exp_cos: model_cos(30'h0C90_FDAA),
                exp_sign: 1'b1, exp_quad: 2'd2};
    vecs[1] = '{angle: 30'h3FFF_FFFF, sign: 1'b0, quad: 2'd1, hold: 0,
                exp_sin: model_sin(30'h3FFF_FFFF), exp_cos: model_cos(30'h3FFF_FFFF),
                exp_sign: 1'b0, exp_quad: 2'd1};
    vecs[2] = '{angle: 30'h0000_0001, sign: 1'b1, quad: 2'd0, hold: 3,
                exp_sin: model_sin(30'h0000_0001), exp_cos: model_cos(30'h0000_0001),
                exp_sign: 1'b1, exp_quad: 2'd0};

    bus.in_valid    = 1'b0;
    bus.in_angle    = '0;
    bus.in_sign     = 1'b0;
    bus.in_quadrant = '0;
    bus.out_ready   = 1'b0;

    // Reset held
    #2;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst out_valid", bus.out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready before edge", bus.in_ready, 0);
    @(negedge clk);
    chk("idle in_ready", bus.in_ready, 1);
    chk("idle busy", bus.busy, 0);
    chk("idle out_valid", bus.out_valid, 0);
    chk("idle core_load", bus.core_load, 0);
    chk("idle core_en", bus.core_en, 0);
    chk("idle core_iter", bus.core_iter, 0);
    chk("idle core_angle", bus.core_angle, 0);
    chk("idle pre_sin", bus.pre_sin, 0);
    chk("idle pre_cos", bus.pre_cos, 0);
    chk("idle sign", bus.sign, 0);
    chk("idle quadrant", bus.quadrant, 0);

    // Table-driven transactions
    for (int k = 0; k < 3; k++) begin
      do_txn(vecs[k]);
      release_result();
    end

    // Result handshake and new request in the same DONE cycle
    do_txn(vecs[1]);
    a2 = 30'h1234_5678;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_angle    = a2;
    bus.in_sign     = 1'b0;
    bus.in_quadrant = 2'd3;
    #1;
    chk("b2b in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("b2b core_load", bus.core_load, 1);
    chk("b2b out_valid", bus.out_valid, 0);
    chk("b2b core_angle", bus.core_angle, a2);
    for (int c = 2; c <= ITER + 1; c++) begin
      @(negedge clk);
      chk($sformatf("b2b core_en c%0d", c), bus.core_en, 1);
    end
    @(negedge clk);
    chk("b2b out_valid", bus.out_valid, 1);
    chk("b2b quadrant", bus.quadrant, 3);
    chk("b2b sign", bus.sign, 0);
    chk("b2b pre_sin", bus.pre_sin, model_sin(a2));
    chk("b2b pre_cos", bus.pre_cos, model_cos(a2));
    release_result();

    // Reset while rotating at core_iter 7
    bus.in_valid    = 1'b1;
    bus.in_angle    = 30'h2AAA_5555;
    bus.in_sign     = 1'b1;
    bus.in_quadrant = 2'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) @(negedge clk);
    chk("pre-rst core_iter", bus.core_iter, 7);
    rst = 1'b1;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst core_en", bus.core_en, 0);
    chk("midrst core_iter", bus.core_iter, 0);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("midrst held out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst recover in_ready", bus.in_ready, 1);
    chk("midrst recover out_valid", bus.out_valid, 0);
    do_txn(vecs[0]);
    release_result();

    // Zero angle
`ifdef CORDIC_ZERO_BYPASS_EN
    bus.in_valid    = 1'b1;
    bus.in_angle    = 30'h0;
    bus.in_sign     = 1'b0;
    bus.in_quadrant = 2'd2;
    #1;
    chk("zero in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("zero out_valid", bus.out_valid, 1);
    chk("zero core_load", bus.core_load, 0);
    chk("zero core_en", bus.core_en, 0);
    chk("zero pre_sin", bus.pre_sin, 30'h0);
    chk("zero pre_cos", bus.pre_cos, 30'h1000_0000);
    chk("zero quadrant", bus.quadrant, 2);
    release_result();
`else
    v = '{angle: 30'h0, sign: 1'b0, quad: 2'd2, hold: 0,
          exp_sin: model_sin(30'h0), exp_cos: model_cos(30'h0),
          exp_sign: 1'b0, exp_quad: 2'd2};
    do_txn(v);
    release_result();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
